// File: rtl/param_stimulus_generator.sv
// rtl/param_stimulus_generator.sv - paced multi-channel pattern source with valid/ready back-pressure
// Patterns: constant, up-count, down-count or 16-bit Galois LFSR, one sample per PERIOD cycles.
module param_stimulus_generator #(
  parameter int SAMPLE_WIDTH = 4,
  parameter int NUM_CHANNELS = 1,
  parameter int PERIOD       = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [1:0]                           mode,
  input  logic [15:0]                          seed,
  input  logic [COUNT_WIDTH-1:0]               sample_count,
  input  logic                                 data_ready,
  output logic                                 data_valid,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] stimulus_stream,
  output logic                                 busy,
  output logic                                 done
);

  localparam int SW = NUM_CHANNELS * SAMPLE_WIDTH;
  // The counter holds PERIOD-2 down to 0, giving PERIOD-1 cycles of WAIT.
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD - 1) : 1;
  localparam logic [PW-1:0] PERIOD_LOAD = PW'((PERIOD > 1) ? PERIOD - 2 : 0);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DONE} state_t;

  state_t                   state, state_next;
  logic [PW-1:0]            period_cnt, cnt_next;
  logic [COUNT_WIDTH-1:0]   remaining, rem_next;
  logic [SAMPLE_WIDTH-1:0]  base, base_next;
  logic [15:0]              lfsr, lfsr_next;
  logic [1:0]               mode_r, mode_next;
  logic [SW-1:0]            stream, stream_next;
  logic                     accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [SW-1:0] pattern(input logic [1:0] m,
                                            input logic [SAMPLE_WIDTH-1:0] b,
                                            input logic [15:0] l);
    logic [SW-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      case (m)
        2'd0:    w[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = b;
        2'd1:    w[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = b + SAMPLE_WIDTH'(i);
        2'd2:    w[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = b - SAMPLE_WIDTH'(i);
        default: w[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = l[SAMPLE_WIDTH-1:0] ^ SAMPLE_WIDTH'(i);
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      remaining  <= '0;
      base       <= '0;
      lfsr       <= LFSR_INIT;
      mode_r     <= 2'd0;
      stream     <= '0;
    end else begin
      state      <= state_next;
      period_cnt <= cnt_next;
      remaining  <= rem_next;
      base       <= base_next;
      lfsr       <= lfsr_next;
      mode_r     <= mode_next;
      stream     <= stream_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = period_cnt;
    rem_next    = remaining;
    base_next   = base;
    lfsr_next   = lfsr;
    mode_next   = mode_r;
    stream_next = stream;
    accept      = (state == PRESENT) && data_ready;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          mode_next  = mode;
          base_next  = seed[SAMPLE_WIDTH-1:0];
          lfsr_next  = (seed == 16'h0000) ? LFSR_INIT : seed;
          rem_next   = sample_count;
          cnt_next   = PERIOD_LOAD;
          state_next = (PERIOD == 1) ? PRESENT : WAIT;
        end
      end
      WAIT: begin
        if (stop)                   state_next = IDLE;
        else if (period_cnt == '0)  state_next = PRESENT;
        else                        cnt_next   = period_cnt - PW'(1);
      end
      PRESENT: begin
        if (accept) begin
          case (mode_r)
            2'd1:    base_next = base + SAMPLE_WIDTH'(1);
            2'd2:    base_next = base - SAMPLE_WIDTH'(1);
            2'd3:    lfsr_next = lfsr_step(lfsr);
            default: ;
          endcase
          // remaining == 0 marks a free-running run; bounded runs leave at 1.
          if (remaining != '0) rem_next = remaining - COUNT_WIDTH'(1);
          cnt_next = PERIOD_LOAD;
          if (stop)                                state_next = IDLE;
          else if (remaining == COUNT_WIDTH'(1))   state_next = DONE;
          else                                     state_next = (PERIOD == 1) ? PRESENT : WAIT;
        end else if (stop) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Load a fresh sample only when a new presentation begins.
    if (state_next == PRESENT && (state != PRESENT || accept))
      stream_next = pattern(mode_next, base_next, lfsr_next);
  end

  assign data_valid      = (state == PRESENT);
  assign stimulus_stream = stream;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_param_stimulus_generator.sv
// tb/tb_param_stimulus_generator.sv - scoreboard bench driving a PERIOD=4 and a PERIOD=1 instance
// Both instances share inputs; a model predicts the sample sequence and pacing per instance.
module tb_param_stimulus_generator;
  logic        clk = 1'b0;
  logic        reset_n, start, stop;
  logic        data_ready = 1'b1;
  logic [1:0]  mode;
  logic [15:0] seed, sample_count;
  logic        va, vb, ba, bb, da, db;
  logic [7:0]  sa, sb;

  int checks = 0, failures = 0, cyc = 0, ready_mode = 1, exp_done = 0;
  logic [7:0] qa[$], qb[$];
  logic       pv[2], pacc[2], pstop[2];
  logic [7:0] ps[2];
  int         trig[2], last_acc[2], done_cnt[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_stimulus_generator #(.SAMPLE_WIDTH(4), .NUM_CHANNELS(2), .PERIOD(4), .COUNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .sample_count(sample_count), .data_ready(data_ready), .data_valid(va),
    .stimulus_stream(sa), .busy(ba), .done(da));

  param_stimulus_generator #(.SAMPLE_WIDTH(4), .NUM_CHANNELS(2), .PERIOD(1), .COUNT_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .sample_count(sample_count), .data_ready(data_ready), .data_valid(vb),
    .stimulus_stream(sb), .busy(bb), .done(db));

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k-th sample of a run, straight from the pattern rules.
  function automatic logic [7:0] model(input logic [1:0] m, input logic [15:0] sd, input int k);
    logic [15:0] l;
    logic [3:0]  b;
    logic [7:0]  w;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int j = 0; j < k; j++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    for (int i = 0; i < 2; i++) begin
      case (m)
        2'd0:    b = sd[3:0];
        2'd1:    b = 4'(int'(sd[3:0]) + k + i);
        2'd2:    b = 4'(int'(sd[3:0]) - k - i);
        default: b = l[3:0] ^ 4'(i);
      endcase
      w[i*4 +: 4] = b;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    #2;
    if (ready_mode == 0)      data_ready = 1'b0;
    else if (ready_mode == 1) data_ready = 1'b1;
    else                      data_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic v, bz, dn, acc;
      logic [7:0] s, e;
      int per;
      v  = (d == 0) ? va : vb;
      bz = (d == 0) ? ba : bb;
      dn = (d == 0) ? da : db;
      s  = (d == 0) ? sa : sb;
      per = (d == 0) ? 4 : 1;
      if (!reset_n) begin
        pv[d] = 1'b0; pacc[d] = 1'b0; pstop[d] = 1'b0;
      end else begin
        acc = v && data_ready;
        if (!bz && start && !stop) trig[d] = cyc + 1;
        if (v && (!pv[d] || pacc[d])) chk(cyc - trig[d] == per - 1, "pace", cyc - trig[d], per - 1);
        if (pv[d] && !pacc[d] && !pstop[d]) begin
          chk(v, "hold_valid", v, 1);
          chk(s == ps[d], "hold_stream", s, ps[d]);
        end
        if (pv[d] && pstop[d]) chk(!v, "stop_valid", v, 0);
        if (acc) begin
          if ((d == 0 ? qa.size() : qb.size()) == 0) chk(0, "unexpected_sample", s, 0);
          else begin
            e = (d == 0) ? qa.pop_front() : qb.pop_front();
            chk(s == e, d == 0 ? "sample_a" : "sample_b", s, e);
          end
          trig[d] = cyc + 1;
          last_acc[d] = cyc + 1;
        end
        if (dn) begin
          done_cnt[d]++;
          chk(!v, "done_valid", v, 0);
          chk(last_acc[d] == cyc, "done_latency", cyc - last_acc[d], 0);
        end
        pv[d] = v; pacc[d] = acc; ps[d] = s; pstop[d] = stop;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [15:0] sd, input logic [15:0] cnt);
    int n;
    n = (cnt == 0) ? 40 : int'(cnt);
    for (int k = 0; k < n; k++) begin
      qa.push_back(model(m, sd, k));
      qb.push_back(model(m, sd, k));
    end
    mode = m; seed = sd; sample_count = cnt; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; seed = ~sd; sample_count = 16'd1;
  endtask

  task automatic finish_run();
    int n = 0;
    while ((ba || bb) && n < 400) begin tick(); n++; end
    chk(n < 400, "idle_timeout", n, 400);
    exp_done++;
    chk(qa.size() == 0, "missing_a", qa.size(), 0);
    chk(qb.size() == 0, "missing_b", qb.size(), 0);
    chk(done_cnt[0] == exp_done, "done_count_a", done_cnt[0], exp_done);
    chk(done_cnt[1] == exp_done, "done_count_b", done_cnt[1], exp_done);
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!va && n < 100) begin tick(); n++; end
    chk(n < 100, "valid_timeout", n, 100);
  endtask

  task automatic check_zero(input string name);
    chk({va, vb, ba, bb, da, db} == 6'b0, name, {va, vb, ba, bb, da, db}, 0);
    chk({sa, sb} == 16'h0, name, {sa, sb}, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; seed = 16'h0; sample_count = 16'h0;
    for (int d = 0; d < 2; d++) begin trig[d] = 0; last_acc[d] = 0; done_cnt[d] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset_n = 1'b1;
    tick();

    start_run(2'd1, 16'd3, 16'd3); finish_run();

    ready_mode = 0;
    start_run(2'd1, 16'd0, 16'd3);
    wait_valid_a();
    repeat (5) tick();
    ready_mode = 1;
    finish_run();

    ready_mode = 1;
    start_run(2'd0, 16'd9, 16'd0);
    repeat (12) tick();
    ready_mode = 0;
    repeat (2) tick();
    wait_valid_a();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk(!va, "stop_valid_a", va, 0);
    chk(!ba && !bb, "stop_idle", {ba, bb}, 0);
    repeat (3) tick();
    chk(done_cnt[0] == exp_done && done_cnt[1] == exp_done, "stop_no_done", done_cnt[0] + done_cnt[1], 2 * exp_done);
    qa.delete(); qb.delete();

    ready_mode = 1;
    start_run(2'd3, 16'($urandom), 16'd0);
    repeat (7) tick();
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk); #1 reset_n = 1'b1;
    qa.delete(); qb.delete();
    tick();

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk(!ba && !bb && !va && !vb, "start_stop_idle", {ba, bb, va, vb}, 0);
      tick();
    end

    start_run(2'd2, 16'd1, 16'd3); finish_run();
    start_run(2'd3, 16'd0, 16'd4); finish_run();

    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      start_run(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(1, 5)));
      finish_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
